// File: rtl/reaction_timer.sv
// reaction_timer: measures player reaction time in ms from lights-out to button press.
// Flags false starts (press while armed) and too-slow timeouts; holds the result until re-armed.
// Optional feature macro: REACTION_BCD_EN adds bcd_out, a 4-digit BCD copy of the ms count.
module reaction_timer #(
  parameter int unsigned CLK_PER_MS = 1000,
  parameter int unsigned MS_W       = 14,
  parameter int unsigned MAX_MS     = 9999
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic            lights_out,
  input  logic            button,
  output logic [MS_W-1:0] reaction_ms,
  output logic            result_valid,
  output logic            false_start,
  output logic            too_slow,
  output logic            busy
`ifdef REACTION_BCD_EN
  ,
  output logic [15:0]     bcd_out
`endif
);

  localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_TIMING,
    S_RESULT
  } state_e;

  state_e          state_q, state_d;
  logic            btn_s1_q, btn_s2_q, btn_s3_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic [MS_W-1:0] res_q, res_d;
  logic            valid_q, valid_d;
  logic            fs_q, fs_d;
  logic            ts_q, ts_d;
  logic            busy_q, busy_d;
  logic            press;
  logic            wrap;

`ifdef REACTION_BCD_EN
  logic [15:0]     bcd_q, bcd_d, bcd_inc;
`endif

  assign press = btn_s2_q & ~btn_s3_q;
  assign wrap  = (presc_q == PW'(CLK_PER_MS - 1));

`ifdef REACTION_BCD_EN
  // Decimal ripple increment: each digit rolls 9->0 and carries into the next.
  always_comb begin
    logic carry;
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd_inc[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_inc[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end
`endif

  // Next-state, counter and result logic; arm overrides everything else.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ms_d    = ms_q;
    res_d   = res_q;
    fs_d    = fs_q;
    ts_d    = ts_q;
`ifdef REACTION_BCD_EN
    bcd_d   = bcd_q;
`endif
    if (arm) begin
      state_d = S_ARMED;
      presc_d = '0;
      ms_d    = '0;
      res_d   = '0;
      fs_d    = 1'b0;
      ts_d    = 1'b0;
`ifdef REACTION_BCD_EN
      bcd_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          if (press) begin
            state_d = S_RESULT;
            fs_d    = 1'b1;
            res_d   = '0;
          end else if (lights_out) begin
            state_d = S_TIMING;
            presc_d = '0;
            ms_d    = '0;
          end
        end
        S_TIMING: begin
          // A press on the saturating wrap wins, so it reports MAX_MS-1.
          if (press) begin
            state_d = S_RESULT;
            res_d   = ms_q;
          end else if (wrap) begin
            presc_d = '0;
            ms_d    = ms_q + MS_W'(1);
`ifdef REACTION_BCD_EN
            bcd_d   = bcd_inc;
`endif
            if (ms_q == MS_W'(MAX_MS - 1)) begin
              state_d = S_RESULT;
              ts_d    = 1'b1;
              res_d   = MS_W'(MAX_MS);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_RESULT: ;
        default: state_d = S_IDLE;
      endcase
    end
    valid_d = (state_d == S_RESULT);
    busy_d  = (state_d == S_ARMED) || (state_d == S_TIMING);
  end

  // State, synchroniser and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      btn_s3_q <= 1'b0;
      presc_q  <= '0;
      ms_q     <= '0;
      res_q    <= '0;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
      ts_q     <= 1'b0;
      busy_q   <= 1'b0;
`ifdef REACTION_BCD_EN
      bcd_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      btn_s1_q <= button;
      btn_s2_q <= btn_s1_q;
      btn_s3_q <= btn_s2_q;
      presc_q  <= presc_d;
      ms_q     <= ms_d;
      res_q    <= res_d;
      valid_q  <= valid_d;
      fs_q     <= fs_d;
      ts_q     <= ts_d;
      busy_q   <= busy_d;
`ifdef REACTION_BCD_EN
      bcd_q    <= bcd_d;
`endif
    end
  end

  assign reaction_ms  = res_q;
  assign result_valid = valid_q;
  assign false_start  = fs_q;
  assign too_slow     = ts_q;
  assign busy         = busy_q;
`ifdef REACTION_BCD_EN
  assign bcd_out      = bcd_q;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: event-timestamp model plus directed literal checks.
module tb_reaction_timer;

  localparam int unsigned CLK  = 4;
  localparam int unsigned MSW  = 14;
`ifdef REACTION_BCD_EN
  localparam int unsigned MAXM = 200;
`else
  localparam int unsigned MAXM = 100;
`endif

  localparam int P_IDLE   = 0;
  localparam int P_ARMED  = 1;
  localparam int P_TIMING = 2;
  localparam int P_RESULT = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           arm = 1'b0;
  logic           lights_out = 1'b0;
  logic           button = 1'b0;
  logic [MSW-1:0] reaction_ms;
  logic           result_valid, false_start, too_slow, busy;
`ifdef REACTION_BCD_EN
  logic [15:0]    bcd_out;
`endif

  always #5 clk = ~clk;

  reaction_timer #(
    .CLK_PER_MS(CLK),
    .MS_W(MSW),
    .MAX_MS(MAXM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .lights_out(lights_out),
    .button(button),
    .reaction_ms(reaction_ms),
    .result_valid(result_valid),
    .false_start(false_start),
    .too_slow(too_slow),
    .busy(busy)
`ifdef REACTION_BCD_EN
    ,
    .bcd_out(bcd_out)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  // Model: phase plus timestamps; ms derived as elapsed edges divided by CLK.
  int m_phase = P_IDLE;
  int m_cyc   = 0;
  int m_L     = 0;
  int m_rm    = 0;
  bit m_fs    = 1'b0;
  bit m_ts    = 1'b0;
  bit m_en    = 1'b0;
  bit hist[$] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    bit mp;
    int k;
    m_cyc++;
    if (!rst) begin
      m_phase = P_IDLE;
      m_rm    = 0;
      m_fs    = 1'b0;
      m_ts    = 1'b0;
      hist    = '{1'b0, 1'b0, 1'b0};
      m_en    = 1'b1;
    end else begin
      // button sampled two and three edges ago decides a press at this edge
      mp = hist[$-1] & ~hist[$-2];
      hist.push_back(button);
      if (hist.size() > 6) void'(hist.pop_front());
      if (arm) begin
        m_phase = P_ARMED;
        m_rm    = 0;
        m_fs    = 1'b0;
        m_ts    = 1'b0;
      end else begin
        case (m_phase)
          P_ARMED: begin
            if (mp) begin
              m_phase = P_RESULT;
              m_fs    = 1'b1;
              m_rm    = 0;
            end else if (lights_out) begin
              m_phase = P_TIMING;
              m_L     = m_cyc;
            end
          end
          P_TIMING: begin
            k = m_cyc - m_L;
            if (mp) begin
              m_phase = P_RESULT;
              m_rm    = (k - 1) / CLK;
            end else if (k / CLK >= MAXM) begin
              m_phase = P_RESULT;
              m_ts    = 1'b1;
              m_rm    = MAXM;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_en) begin
      chk("model_reaction_ms", int'(reaction_ms), (m_phase == P_RESULT) ? m_rm : 0);
      chk("model_result_valid", int'(result_valid), int'(m_phase == P_RESULT));
      chk("model_false_start", int'(false_start), int'(m_fs));
      chk("model_too_slow", int'(too_slow), int'(m_ts));
      chk("model_busy", int'(busy), int'(m_phase == P_ARMED || m_phase == P_TIMING));
`ifdef REACTION_BCD_EN
      chk("model_bcd", int'(bcd_out),
          (m_phase == P_RESULT) ? to_bcd(m_rm) :
          (m_phase == P_TIMING) ? to_bcd((m_cyc - m_L) / CLK) : 0);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  task automatic pulse_lights();
    lights_out = 1'b1;
    cyc(1);
    lights_out = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // reset and pre-arm inputs ignored
    cyc(2);
    chk("reset_reaction_ms", int'(reaction_ms), 0);
    chk("reset_valid", int'(result_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_flags", int'({false_start, too_slow}), 0);
    rst = 1'b1;
    pulse_lights();
    button = 1'b1;
    cyc(6);
    chk("idle_ignore_busy", int'(busy), 0);
    chk("idle_ignore_valid", int'(result_valid), 0);
    button = 1'b0;
    cyc(4);

    // normal reaction: 41 cycles after lights_out -> 10 ms
    pulse_arm();
    cyc(19);
    pulse_lights();
    cyc(40);
    button = 1'b1;
    cyc(6);
    chk("react_ms", int'(reaction_ms), 10);
    chk("react_valid", int'(result_valid), 1);
    chk("react_flags", int'({false_start, too_slow}), 0);
    chk("react_busy", int'(busy), 0);
    button = 1'b0;
    cyc(4);

    // false start
    pulse_arm();
    cyc(4);
    button = 1'b1;
    cyc(6);
    chk("fs_flag", int'(false_start), 1);
    chk("fs_ms", int'(reaction_ms), 0);
    chk("fs_valid", int'(result_valid), 1);
    button = 1'b0;
    cyc(4);

    // timeout, then a late press is ignored
    pulse_arm();
    cyc(2);
    pulse_lights();
    w = 0;
    while (w < 1000 && !result_valid) begin
      cyc(1);
      w++;
    end
    chk("timeout_cycles", w, 400 * MAXM / 100);
    chk("timeout_flag", int'(too_slow), 1);
    chk("timeout_ms", int'(reaction_ms), MAXM);
    button = 1'b1;
    cyc(6);
    chk("late_press_ms", int'(reaction_ms), MAXM);
    chk("late_press_flag", int'(too_slow), 1);
    chk("late_press_valid", int'(result_valid), 1);
    button = 1'b0;
    cyc(4);

    // re-arm mid-timing
    pulse_arm();
    cyc(1);
    pulse_lights();
    cyc(29);
    pulse_arm();
    cyc(1);
    chk("rearm_busy", int'(busy), 1);
    chk("rearm_valid", int'(result_valid), 0);
    chk("rearm_ms", int'(reaction_ms), 0);
    pulse_lights();
    cyc(7);
    button = 1'b1;
    cyc(6);
    chk("rearm_react_ms", int'(reaction_ms), 2);
    chk("rearm_react_valid", int'(result_valid), 1);
    button = 1'b0;
    cyc(4);

    // press on the saturating wrap counts as a press
    pulse_arm();
    cyc(1);
    pulse_lights();
    cyc(MAXM * CLK - 3);
    button = 1'b1;
    cyc(6);
    chk("sat_press_ms", int'(reaction_ms), MAXM - 1);
    chk("sat_press_slow", int'(too_slow), 0);
    button = 1'b0;
    cyc(4);

    // press and lights_out on the same edge in ARMED: press wins
    pulse_arm();
    cyc(2);
    button = 1'b1;
    cyc(2);
    pulse_lights();
    cyc(4);
    chk("prio_fs_flag", int'(false_start), 1);
    chk("prio_fs_busy", int'(busy), 0);
    button = 1'b0;
    cyc(4);

    // arm and press on the same edge in TIMING: arm wins
    pulse_arm();
    cyc(1);
    pulse_lights();
    cyc(10);
    button = 1'b1;
    cyc(2);
    pulse_arm();
    cyc(3);
    chk("prio_arm_busy", int'(busy), 1);
    chk("prio_arm_valid", int'(result_valid), 0);
    button = 1'b0;
    cyc(4);
    pulse_lights();
    cyc(12);
    button = 1'b1;
    cyc(6);
    chk("prio_arm_react_ms", int'(reaction_ms), 3);
    button = 1'b0;
    cyc(4);

`ifdef REACTION_BCD_EN
    // 123 ms reaction with decimal readout
    pulse_arm();
    cyc(1);
    pulse_lights();
    cyc(491);
    button = 1'b1;
    cyc(6);
    chk("bcd_ms", int'(reaction_ms), 123);
    chk("bcd_digits", int'(bcd_out), 16'h0123);
    button = 1'b0;
    cyc(4);
`endif

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
